// File: rtl/pulse_spacer_pkg.sv
// Shared parameters, types and helpers for the pulse_spacer block.
// Holds the T_SEP/DEPTH defaults, the pending-count width function and the arbiter pointer.
package pulse_spacer_pkg;

    localparam int T_SEP_DEF = 10;
    localparam int DEPTH_DEF = 4;
    localparam int GAP_W     = 8;

    typedef enum logic {
        PTR_CH1 = 1'b0,
        PTR_CH2 = 1'b1
    } arb_ptr_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pulse_pend_ctr.sv
// Per-channel saturating pending-pulse counter (0..DEPTH).
// Ports: clk, rst_n, arrive, grant in; cnt, req (pending or arriving), drop (arrival lost) out.
module pulse_pend_ctr
    import pulse_spacer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arrive,
    input  logic          grant,
    output logic [CW-1:0] cnt,
    output logic          req,
    output logic          drop
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt = cnt_q;
    assign req = (cnt_q != '0) || arrive;

    // An arrival granted in the same cycle passes straight through.
    always_comb begin
        cnt_d = cnt_q;
        drop  = 1'b0;
        unique case (1'b1)
            (arrive && !grant): begin
                if (cnt_q == CW'(DEPTH)) begin
                    drop = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            (!arrive && grant): begin
                cnt_d = cnt_q - CW'(1);
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_spacer.sv
// Two-channel pulse spacer: queues pulses and emits them at least T_SEP cycles apart.
// Ports: clk, rst_n, in1, in2, ovf_clr in; out1, out2, busy, ovf (drop_cnt with PULSE_SPACER_STATS_EN) out.
module pulse_spacer
    import pulse_spacer_pkg::*;
#(
    parameter int T_SEP = T_SEP_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in1,
    input  logic        in2,
    input  logic        ovf_clr,
    output logic        out1,
    output logic        out2,
    output logic        busy,
    output logic        ovf
`ifdef PULSE_SPACER_STATS_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0]    cnt1;
    logic [CW-1:0]    cnt2;
    logic             req1;
    logic             req2;
    logic             gnt1;
    logic             gnt2;
    logic             drop1;
    logic             drop2;
    logic             emit;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    arb_ptr_e         ptr_q;
    arb_ptr_e         ptr_d;

    pulse_pend_ctr #(.DEPTH(DEPTH), .CW(CW)) u_ctr1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .arrive (in1),
        .grant  (gnt1),
        .cnt    (cnt1),
        .req    (req1),
        .drop   (drop1)
    );

    pulse_pend_ctr #(.DEPTH(DEPTH), .CW(CW)) u_ctr2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .arrive (in2),
        .grant  (gnt2),
        .cnt    (cnt2),
        .req    (req2),
        .drop   (drop2)
    );

    // The pointer only moves when both channels compete.
    always_comb begin
        gnt1  = 1'b0;
        gnt2  = 1'b0;
        ptr_d = ptr_q;
        if (gap_q == '0) begin
            unique case ({req1, req2})
                2'b11: begin
                    gnt1  = (ptr_q == PTR_CH1);
                    gnt2  = (ptr_q == PTR_CH2);
                    ptr_d = (ptr_q == PTR_CH1) ? PTR_CH2 : PTR_CH1;
                end
                2'b10:   gnt1 = 1'b1;
                2'b01:   gnt2 = 1'b1;
                default: ;
            endcase
        end
    end

    assign emit = gnt1 | gnt2;

    // Loading T_SEP-1 gives exactly T_SEP cycles between back-to-back pulses.
    always_comb begin
        gap_d = gap_q;
        if (emit) begin
            gap_d = GAP_W'(T_SEP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_CH1;
            gap_q <= '0;
            out1  <= 1'b0;
            out2  <= 1'b0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            gap_q <= gap_d;
            out1  <= gnt1;
            out2  <= gnt2;
            busy  <= (cnt1 != '0) || (cnt2 != '0) ||
                     (gap_q != '0) || in1 || in2;
            if (drop1 || drop2) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef PULSE_SPACER_STATS_EN
    logic [1:0]  drops;
    logic [15:0] drop_base;
    logic [16:0] drop_sum;

    assign drops     = {1'b0, drop1} + {1'b0, drop2};
    assign drop_base = ovf_clr ? 16'h0000 : drop_cnt;
    assign drop_sum  = {1'b0, drop_base} + {15'b0, drops};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer (T_SEP=10, DEPTH=4).
// Arithmetic reference model compared every cycle, plus literal scenario expectations.
module tb_pulse_spacer;

    localparam int T_SEP = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in1 = 1'b0;
    logic in2 = 1'b0;
    logic ovf_clr = 1'b0;
    logic out1;
    logic out2;
    logic busy;
    logic ovf;
`ifdef PULSE_SPACER_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int tcyc = 0;
    int n_o1 = 0;
    bit chk_en = 1'b0;

    int p1, p2, turn, last, mc, e_drop;
    bit e_o1, e_o2, e_busy, e_ovf;

    pulse_spacer #(.T_SEP(T_SEP), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in1      (in1),
        .in2      (in2),
        .ovf_clr  (ovf_clr),
        .out1     (out1),
        .out2     (out2),
        .busy     (busy),
        .ovf      (ovf)
`ifdef PULSE_SPACER_STATS_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h",
                     name, tcyc, act, exp);
        end
    endtask

    task automatic model_reset();
        p1 = 0; p2 = 0; turn = 1; last = -1000; mc = 0;
        e_o1 = 0; e_o2 = 0; e_busy = 0; e_ovf = 0; e_drop = 0;
    endtask

    // Cycle-level model: a pulse visible in cycle L blocks the next until L+T_SEP.
    task automatic model_tick();
        bit ok, r1, r2;
        int g, d;
        ok = (mc - last) >= T_SEP - 1;
        r1 = (p1 > 0) || in1;
        r2 = (p2 > 0) || in2;
        e_busy = (p1 > 0) || (p2 > 0) || !ok || in1 || in2;
        g = 0;
        if (ok && r1 && r2) begin
            g = turn;
            turn = 3 - turn;
        end else if (ok && r1) begin
            g = 1;
        end else if (ok && r2) begin
            g = 2;
        end
        d = 0;
        p1 = p1 + int'(in1) - int'(g == 1);
        if (p1 > DEPTH) begin p1 = DEPTH; d++; end
        p2 = p2 + int'(in2) - int'(g == 2);
        if (p2 > DEPTH) begin p2 = DEPTH; d++; end
        if (d > 0) e_ovf = 1;
        else if (ovf_clr) e_ovf = 0;
        e_drop = ovf_clr ? d : e_drop + d;
        if (e_drop > 65535) e_drop = 65535;
        e_o1 = (g == 1);
        e_o2 = (g == 2);
        if (g != 0) last = mc + 1;
        mc++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_tick();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out1", out1, e_o1);
            check("m_out2", out2, e_o2);
            check("m_busy", busy, e_busy);
            check("m_ovf", ovf, e_ovf);
`ifdef PULSE_SPACER_STATS_EN
            check("m_drop_cnt", drop_cnt, e_drop);
`endif
            if (out1) n_o1++;
        end
    end

    task automatic run(input int n, input logic a, input logic b,
                       input logic c);
        for (int i = 0; i < n; i++) begin
            in1 = a; in2 = b; ovf_clr = c;
            @(posedge clk);
            #1;
            tcyc++;
        end
        in1 = 0; in2 = 0; ovf_clr = 0;
    endtask

    task automatic do_reset();
        in1 = 0; in2 = 0; ovf_clr = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out1", out1, 0);
        check("rst_out2", out2, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1;
        tcyc = 0;
        n_o1 = 0;
        chk_en = 1;
    endtask

    initial begin
        // single in1 at cycle 5
        do_reset();
        run(5, 0, 0, 0);
        run(1, 1, 0, 0);
        check("s1_out1_c6", out1, 1);
        check("s1_busy_c6", busy, 1);
        run(1, 0, 0, 0);
        check("s1_out1_c7", out1, 0);
        run(8, 0, 0, 0);
        check("s1_busy_c15", busy, 1);
        run(1, 0, 0, 0);
        check("s1_busy_c16", busy, 0);

        // simultaneous in1/in2
        do_reset();
        run(5, 0, 0, 0);
        run(1, 1, 1, 0);
        check("s2_out1_c6", out1, 1);
        check("s2_out2_c6", out2, 0);
        run(10, 0, 0, 0);
        check("s2_out2_c16", out2, 1);
        check("s2_out1_c16", out1, 0);
        check("s2_ovf", ovf, 0);

        // overflow on channel 1
        do_reset();
        run(5, 0, 0, 0);
        run(5, 1, 0, 0);
        check("s3_ovf_c10", ovf, 0);
        run(1, 1, 0, 0);
        check("s3_ovf_c11", ovf, 1);
        run(35, 0, 0, 0);
        check("s3_out1_c46", out1, 1);
        run(14, 0, 0, 0);
        check("s3_pulses", n_o1, 5);
`ifdef PULSE_SPACER_STATS_EN
        check("s3_drop_cnt", drop_cnt, 1);
`endif

        // continuous contention
        do_reset();
        run(5, 0, 0, 0);
        run(1, 1, 1, 0);
        check("s4_out1_c6", out1, 1);
        check("s4_out2_c6", out2, 0);
        run(10, 1, 1, 0);
        check("s4_out2_c16", out2, 1);
        check("s4_out1_c16", out1, 0);
        run(10, 1, 1, 0);
        check("s4_out1_c26", out1, 1);
        run(9, 1, 1, 0);
        run(1, 0, 0, 0);
        check("s4_out2_c36", out2, 1);
        run(100, 0, 0, 0);
        check("s4_idle", busy, 0);

        // reset mid-backlog
        do_reset();
        run(5, 0, 0, 0);
        run(15, 1, 0, 0);
        check("s5_ovf_c20", ovf, 1);
        rst_n = 0;
        #1;
        check("s5_rst_out1", out1, 0);
        check("s5_rst_out2", out2, 0);
        check("s5_rst_ovf", ovf, 0);
        check("s5_rst_busy", busy, 0);
        run(1, 0, 0, 0);
        rst_n = 1;
        run(5, 0, 0, 0);
        check("s5_out1_c26", out1, 0);
        run(4, 0, 0, 0);
        run(1, 0, 1, 0);
        check("s5_out2_c31", out2, 1);
        check("s5_busy_c31", busy, 1);

        // ovf set beats ovf_clr
        do_reset();
        run(5, 0, 0, 0);
        run(5, 1, 0, 0);
        run(1, 1, 0, 1);
        check("s6_ovf_c11", ovf, 1);
        run(9, 0, 0, 0);
        run(1, 0, 0, 1);
        check("s6_ovf_c21", ovf, 0);
        run(50, 0, 0, 0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_spacer.md
PULSE_SPACER -- requirements
Module: pulse_spacer

Interface
REQ-001 SHALL have parameter T_SEP, default 10, minimum cycles between successive output pulses on either output (legal 2..255).
REQ-002 SHALL have parameter DEPTH, default 4, maximum pending pulses held per channel (legal 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in1, input, 1, channel-1 request; each cycle sampled high counts as one pulse.
REQ-006 SHALL have port in2, input, 1, channel-2 request; same rules as in1.
REQ-007 SHALL have port ovf_clr, input, 1, synchronous clear of ovf.
REQ-008 SHALL have port out1, output, 1, registered single-cycle pulse driving confluence input 1.
REQ-009 SHALL have port out2, output, 1, registered single-cycle pulse driving confluence input 2.
REQ-010 SHALL have port busy, output, 1, high while the gap counter is nonzero or any pulse is pending.
REQ-011 SHALL have port ovf, output, 1, sticky flag: a pulse was dropped.

Function
REQ-012 SHALL keep a pending count per channel, 0..DEPTH; request = count>0 or input high this cycle.
REQ-013 SHALL keep a gap counter; emission allowed only when gap==0; on emission gap loads T_SEP-1, else decrements to 0.
REQ-014 SHALL emit at most one pulse per cycle across out1/out2; out1 and out2 never high together.
REQ-015 SHALL give minimum latency of 1 cycle: in1 high at edge N with idle block -> out1 high after edge N+1 for one cycle.
REQ-016 SHALL space successive outputs by at least T_SEP cycles, exactly T_SEP under continuous backlog.
REQ-017 SHALL arbitrate round-robin when both channels request; pointer starts at channel 1 after reset, toggles after each contested grant only.
REQ-018 SHALL net arrival and grant in one cycle: arrive and grant -> count unchanged; arrive only -> +1; grant only -> -1.
REQ-019 SHALL drop an arrival that would push count above DEPTH, count stays DEPTH, ovf sets next edge.
REQ-020 SHALL let ovf set win over ovf_clr in the same cycle.
REQ-021 SHALL hold busy low only when both counts are 0, gap==0, and no input is high.

Reset
REQ-022 SHALL on rst_n low immediately clear out1, out2, ovf, busy, both counts and gap, and set the pointer to channel 1.
REQ-023 SHALL discard pending pulses when reset asserts mid-backlog; first post-reset emission obeys REQ-015 with no gap carried over.

Configuration
REQ-024 SHALL with PULSE_SPACER_STATS_EN defined add output drop_cnt, 16 bits, counting dropped pulses (both channels, 2 per cycle if both drop), saturating at 0xFFFF, cleared by reset and ovf_clr.
REQ-025 SHALL without PULSE_SPACER_STATS_EN have no drop_cnt port or logic; all other behaviour identical.

Structure
REQ-026 SHALL place T_SEP/DEPTH defaults, the count-width function and the arbiter-pointer enum in package pulse_spacer_pkg.
REQ-027 SHALL implement the per-channel saturating pending counter as sub-module pulse_pend_ctr, instantiated twice.

Verification (T_SEP=10, DEPTH=4 unless stated)
REQ-028 SHALL cover: single in1 at cycle 5, idle -> out1 at cycle 6 only, busy high cycles 6..15.
REQ-029 SHALL cover: in1 and in2 together at cycle 5 -> out1 at 6, out2 at 16, no ovf.
REQ-030 SHALL cover: in1 high cycles 5..10 (6 pulses) -> 5 emitted at 6,16,26,36,46, ovf high from cycle 11, drop_cnt=1 with macro.
REQ-031 SHALL cover: continuous in1 and in2 for 30 cycles -> outputs alternate out1,out2 every 10 cycles, pointer starts channel 1.
REQ-032 SHALL cover: rst_n low at cycle 20 during backlog -> outputs, counts and ovf 0 at once; in2 at cycle 30 -> out2 at 31.
REQ-033 SHALL cover: ovf_clr pulse in the cycle a drop occurs -> ovf stays 1; later ovf_clr alone -> ovf 0.
